hilo_muldiv_unit: RTL and testbench

Multi-cycle multiply/divide unit with the architectural HI/LO register pair, sitting in the EX stage directly upstream of the EX/MEM pipeline register. It drives the HI and LO inputs of that register and raises Busy so the hazard unit stalls the pipeline while an operation is in flight. It supports MULT, MULTU, DIV, DIVU, MADD, MSUB, MTHI and MTLO.

---
 rtl/hilo_muldiv_unit.sv | 136 +++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: fixed-latency multiply/accumulate and a radix-2
// restoring divider. Busy stalls the pipeline while an operation is in flight.
module hilo_muldiv_unit #(
    parameter int MUL_LAT = 4
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Flush,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3;
    localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3,
                           OP_MADD = 3'd4, OP_MSUB = 3'd5, OP_MTHI = 3'd6, OP_MTLO = 3'd7;

    logic [1:0]         state;
    logic [4:0]         cnt;
    logic [2:0]         op_q;
    logic [31:0]        a_q, b_q, quo_q, rem_q, dvs_q;
    logic               issue, div_signed, is_div;
    logic signed [63:0] a_ext, b_ext;
    logic [63:0]        prod, acc_res;
    logic [32:0]        trial;
    logic [31:0]        q_fix, r_fix;

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

    assign issue      = (state == S_IDLE) && Start && !Flush;
    assign div_signed = (op_q == OP_DIV);
    assign is_div     = (op_q == OP_DIV) || (op_q == OP_DIVU);

    always_comb begin
        // Zero-extending for MULTU keeps one signed 64x64 multiply for every op;
        // only the low 64 bits are used.
        a_ext = (op_q == OP_MULTU) ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
        b_ext = (op_q == OP_MULTU) ? {32'd0, b_q} : {{32{b_q[31]}}, b_q};
        prod  = a_ext * b_ext;
        case (op_q)
            OP_MADD: acc_res = {HI, LO} + prod;
            OP_MSUB: acc_res = {HI, LO} - prod;
            default: acc_res = prod;
        endcase
        trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
        q_fix = neg_if(div_signed && (a_q[31] ^ b_q[31]), quo_q);
        r_fix = neg_if(div_signed && a_q[31], rem_q);
    end

    // Operand capture and divider iteration (no reset needed on datapath state)
    always_ff @(posedge Clk) begin
        if (issue) begin
            op_q  <= Op;
            a_q   <= A;
            b_q   <= B;
            rem_q <= '0;
            quo_q <= neg_if((Op == OP_DIV) && A[31], A);
            dvs_q <= neg_if((Op == OP_DIV) && B[31], B);
        end else if (state == S_DIV) begin
            if (!trial[32]) begin
                rem_q <= trial[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= {rem_q[30:0], quo_q[31]};
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    // Sequencing and architectural HI/LO
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state <= S_IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        case (Op)
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                            OP_DIV, OP_DIVU: begin
                                Busy <= 1'b1;
                                if (B == 32'd0) begin
                                    state <= S_FIX;
                                end else begin
                                    state <= S_DIV;
                                    cnt   <= 5'd31;
                                end
                            end
                            default: begin
                                Busy  <= 1'b1;
                                state <= S_MUL;
                                cnt   <= 5'(MUL_LAT - 1);
                            end
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (Flush) begin
                        state <= S_IDLE;
                        Busy  <= 1'b0;
                    end else if (cnt == 5'd0) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                    if (!Flush) begin
                        Done <= 1'b1;
                        if (is_div) begin
                            if (b_q == 32'd0) {HI, LO} <= {a_q, 32'hFFFF_FFFF};
                            else              {HI, LO} <= {r_fix, q_fix};
                        end else begin
                            {HI, LO} <= acc_res;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: vector table of back-to-back ops plus
// hand-written flush, busy-issue and reset sequences.
module tb_hilo_muldiv_unit;
    logic        Clk, Clr, Start, Flush;
    logic [2:0]  Op;
    logic [31:0] A, B;
    logic        Busy, Done;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;

    hilo_muldiv_unit #(.MUL_LAT(4)) dut (
        .Clk(Clk), .Clr(Clr), .Start(Start), .Op(Op), .A(A), .B(B),
        .Flush(Flush), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_op(input int idx, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input int elat);
        int cyc;
        Start = 1'b1; Op = op; A = a; B = b;
        step();
        Start = 1'b0;
        cyc = 0;
        while (Busy === 1'b1 && cyc < 100) begin
            cyc++;
            step();
        end
        chk($sformatf("v%0d_busy_cycles", idx), 32'(cyc), 32'(elat));
        chk($sformatf("v%0d_hi", idx), HI, ehi);
        chk($sformatf("v%0d_lo", idx), LO, elo);
        chk($sformatf("v%0d_done", idx), {31'd0, Done}, {31'd0, elat != 0});
        step();
        chk($sformatf("v%0d_done_drop", idx), {31'd0, Done}, 32'd0);
    endtask

    initial begin
        int  cyc;
        logic seen;

        // op, a, b, expected hi, expected lo, busy cycles
        vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, 5};
        vecs[2]  = '{3'd6, 32'd0,         32'd0,        32'h0000_0000, 32'hFFFF_FFFA, 0};
        vecs[3]  = '{3'd7, 32'd10,        32'd0,        32'h0000_0000, 32'h0000_000A, 0};
        vecs[4]  = '{3'd4, 32'd3,         32'd4,        32'h0000_0000, 32'h0000_0016, 5};
        vecs[5]  = '{3'd5, 32'd5,         32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 5};
        vecs[6]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[7]  = '{3'd3, 32'd7,         32'd2,        32'h0000_0001, 32'h0000_0003, 33};
        vecs[8]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
        vecs[9]  = '{3'd2, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF, 1};
        vecs[10] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[11] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33};
        vecs[12] = '{3'd3, 32'hFFFF_FFFF, 32'd16,       32'h0000_000F, 32'h0FFF_FFFF, 33};
        vecs[13] = '{3'd5, 32'hFFFF_FFFF, 32'd1,        32'h0000_000F, 32'h1000_0000, 5};

        Clr = 1'b1; Start = 1'b0; Flush = 1'b0; Op = '0; A = '0; B = '0;
        step();
        step();
        Clr = 1'b0;
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);

        for (int i = 0; i < 14; i++)
            run_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat);

        // Flush a divide part way through
        run_op(20, 3'd6, 32'h11, 32'd0, 32'h11, 32'h1000_0000, 0);
        run_op(21, 3'd7, 32'h22, 32'd0, 32'h11, 32'h22, 0);
        Start = 1'b1; Op = 3'd2; A = 32'd100; B = 32'd3;
        step();
        Start = 1'b0;
        repeat (9) step();
        chk("flush_pre_busy", {31'd0, Busy}, 32'd1);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        chk("flush_busy", {31'd0, Busy}, 32'd0);
        chk("flush_done", {31'd0, Done}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (Done === 1'b1 || Busy === 1'b1) seen = 1'b1;
            step();
        end
        chk("flush_no_result", {31'd0, seen}, 32'd0);
        chk("flush_hi", HI, 32'h11);
        chk("flush_lo", LO, 32'h22);

        // Flush while the divide-by-zero result is about to be written
        Start = 1'b1; Op = 3'd2; A = 32'd5; B = 32'd0;
        step();
        Start = 1'b0;
        chk("dz_flush_busy_pre", {31'd0, Busy}, 32'd1);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        chk("dz_flush_busy", {31'd0, Busy}, 32'd0);
        chk("dz_flush_done", {31'd0, Done}, 32'd0);
        chk("dz_flush_hi", HI, 32'h11);
        chk("dz_flush_lo", LO, 32'h22);

        // Flush together with Start in IDLE drops the Start
        Flush = 1'b1; Start = 1'b1; Op = 3'd6; A = 32'hDEAD;
        step();
        Flush = 1'b0; Start = 1'b0;
        chk("flush_start_hi", HI, 32'h11);
        chk("flush_start_busy", {31'd0, Busy}, 32'd0);

        // Start while busy is ignored; operands change under the running multiply
        Start = 1'b1; Op = 3'd0; A = 32'd3; B = 32'd5;
        step();
        cyc = 0;
        while (Busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (cyc == 3) begin
                Start = 1'b1; Op = 3'd3; A = 32'd100; B = 32'd7;
            end else begin
                Start = 1'b0;
            end
            step();
        end
        Start = 1'b0;
        chk("busy_issue_cycles", 32'(cyc), 32'd5);
        chk("busy_issue_hi", HI, 32'd0);
        chk("busy_issue_lo", LO, 32'd15);
        chk("busy_issue_done", {31'd0, Done}, 32'd1);
        step();
        chk("busy_issue_idle", {31'd0, Busy}, 32'd0);

        // Reset in the middle of a divide
        run_op(22, 3'd6, 32'h33, 32'd0, 32'h33, 32'd15, 0);
        Start = 1'b1; Op = 3'd2; A = 32'd100; B = 32'd7;
        step();
        Start = 1'b0;
        repeat (5) step();
        Clr = 1'b1;
        step();
        step();
        Clr = 1'b0;
        chk("clr_hi", HI, 32'd0);
        chk("clr_lo", LO, 32'd0);
        chk("clr_busy", {31'd0, Busy}, 32'd0);
        chk("clr_done", {31'd0, Done}, 32'd0);
        repeat (40) step();
        chk("clr_stays_idle", {31'd0, Busy}, 32'd0);
        chk("clr_lo_held", LO, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
